// File: rtl/bus_interconnect.sv
// bus_interconnect: even/odd bank region decoder, wait-state stall FSM and read-return mux.
// Optional BUS_INTERCONNECT_ERR_LATCH_EN: sticky bus_error with err_addr capture and err_clear.
//
// state | meaning
// IDLE  | decode; accept immediately when no wait states are needed
// WAIT  | counting down wait states, cpu held by stall
module bus_interconnect #(
    parameter int                          NREGIONS     = 4,
    parameter int                          ADDRW        = 15,
    parameter int                          DATAW        = 8,
    parameter logic [NREGIONS*ADDRW-1:0]   REGION_BASE  = '0,
    parameter logic [NREGIONS*ADDRW-1:0]   REGION_LIMIT = {NREGIONS{{ADDRW{1'b1}}}},
    parameter logic [NREGIONS*2-1:0]       REGION_WAIT  = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDRW-1:0]          read_addr_even,
    input  logic [ADDRW-1:0]          read_addr_odd,
    input  logic [ADDRW-1:0]          write_addr_even,
    input  logic [ADDRW-1:0]          write_addr_odd,
    input  logic                      write_en_even,
    input  logic                      write_en_odd,
    input  logic [NREGIONS*DATAW-1:0] tgt_read_data_even,
    input  logic [NREGIONS*DATAW-1:0] tgt_read_data_odd,
    output logic [NREGIONS-1:0]       tgt_write_en_even,
    output logic [NREGIONS-1:0]       tgt_write_en_odd,
    output logic [DATAW-1:0]          read_data_even,
    output logic [DATAW-1:0]          read_data_odd,
    output logic                      stall,
    output logic                      bus_error,
    output logic [ADDRW-1:0]          err_addr,
    input  logic                      err_clear
);
    localparam int IDXW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [IDXW-1:0]   sel_even_q, sel_odd_q;
    logic              mapped_even_q, mapped_odd_q;
    logic              bus_error_q;

    // Slot order 0..3 = even read, even write, odd read, odd write; also the fault priority.
    logic [ADDRW-1:0]  addr [4];
    logic [IDXW-1:0]   idx  [4];
    logic [3:0]        active;
    logic [3:0]        mapped;
    logic [1:0]        wait_max;
    logic [ADDRW:0]    lo_diff, hi_diff;
    logic              accept;
    logic              err_d;

    always_comb begin
        addr[0]  = read_addr_even;
        addr[1]  = write_addr_even;
        addr[2]  = read_addr_odd;
        addr[3]  = write_addr_odd;
        active   = {write_en_odd, 1'b1, write_en_even, 1'b1};
        mapped   = '0;
        wait_max = '0;
        lo_diff  = '0;
        hi_diff  = '0;
        for (int a = 0; a < 4; a++) begin
            idx[a] = '0;
            // Descending scan so the lowest matching region is the one left selected.
            for (int r = NREGIONS - 1; r >= 0; r--) begin
                lo_diff = {1'b0, addr[a]} - {1'b0, REGION_BASE[r*ADDRW +: ADDRW]};
                hi_diff = {1'b0, REGION_LIMIT[r*ADDRW +: ADDRW]} - {1'b0, addr[a]};
                if (!lo_diff[ADDRW] && !hi_diff[ADDRW]) begin
                    mapped[a] = 1'b1;
                    idx[a]    = IDXW'(r);
                end
            end
            if (mapped[a] && active[a] && (REGION_WAIT[idx[a]*2 +: 2] > wait_max))
                wait_max = REGION_WAIT[idx[a]*2 +: 2];
        end
    end

    always_comb begin
        stall  = 1'b0;
        accept = 1'b0;
        if (reset_n) begin
            if (state_q == IDLE) begin
                stall  = (wait_max != 2'd0);
                accept = (wait_max == 2'd0);
            end else begin
                stall  = (cnt_q != 2'd0);
                accept = (cnt_q == 2'd0);
            end
        end
    end

    always_comb begin
        tgt_write_en_even = '0;
        tgt_write_en_odd  = '0;
        if (accept && write_en_even && mapped[1])
            tgt_write_en_even[idx[1]] = 1'b1;
        if (accept && write_en_odd && mapped[3])
            tgt_write_en_odd[idx[3]] = 1'b1;
    end

`ifdef BUS_INTERCONNECT_ERR_LATCH_EN
    logic [ADDRW-1:0]  err_addr_q;
    logic [ADDRW-1:0]  fault_addr;

    always_comb begin
        err_d      = 1'b0;
        fault_addr = '0;
        for (int a = 3; a >= 0; a--) begin
            if (active[a] && !mapped[a]) begin
                err_d      = accept;
                fault_addr = addr[a];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_addr_q <= '0;
        end else if (err_d && (!bus_error_q || err_clear)) begin
            err_addr_q <= fault_addr;
        end else if (err_clear) begin
            err_addr_q <= '0;
        end
    end

    assign err_addr = err_addr_q;
`else
    logic unused_err_clear;

    always_comb begin
        err_d = 1'b0;
        for (int a = 0; a < 4; a++) begin
            if (active[a] && !mapped[a])
                err_d = accept;
        end
    end

    assign unused_err_clear = err_clear;
    assign err_addr         = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sel_even_q    <= '0;
            sel_odd_q     <= '0;
            mapped_even_q <= 1'b0;
            mapped_odd_q  <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wait_max != 2'd0) begin
                        state_q <= WAIT;
                        cnt_q   <= wait_max - 2'd1;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'd0)
                        cnt_q <= cnt_q - 2'd1;
                    else
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                sel_even_q    <= idx[0];
                mapped_even_q <= mapped[0];
                sel_odd_q     <= idx[2];
                mapped_odd_q  <= mapped[2];
            end
`ifdef BUS_INTERCONNECT_ERR_LATCH_EN
            if (err_d && (!bus_error_q || err_clear))
                bus_error_q <= 1'b1;
            else if (err_clear)
                bus_error_q <= 1'b0;
`else
            bus_error_q <= err_d;
`endif
        end
    end

    assign bus_error      = bus_error_q;
    assign read_data_even = mapped_even_q ? tgt_read_data_even[sel_even_q*DATAW +: DATAW] : '1;
    assign read_data_odd  = mapped_odd_q  ? tgt_read_data_odd[sel_odd_q*DATAW +: DATAW]   : '1;

endmodule
